// File: rtl/mm_mac_sequencer_pkg.sv
// mm_pkg: shared constants, FSM encoding and element indexing for the 3x3 MAC sequencer.
package mm_pkg;
    localparam int MM_N = 3;
    localparam int MM_DATA_W = 8;
    localparam int MM_ACC_W = 18;
    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, DRAIN = 2'b10} state_t;
    function automatic int idx(input int i, input int j);
        return MM_N * i + j;
    endfunction
endpackage

// File: rtl/mm_mac_sequencer_if.sv
// mm_mac_sequencer_if: operand/control bus between the sequencer and the shared MAC unit.
interface mm_mac_sequencer_if
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W = MM_ACC_W
);
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic mac_en;
    logic mac_clr;
    logic [ACC_W-1:0] mac_acc;
    modport master(output mac_a, mac_b, mac_en, mac_clr, input mac_acc);
    modport slave(input mac_a, mac_b, mac_en, mac_clr, output mac_acc);
endinterface

// File: rtl/mm_mac_unit.sv
// mm_mac_unit: single unsigned multiply-accumulate; clr restarts the sum from the current product.
module mm_mac_unit
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W = MM_ACC_W
) (
    input logic clk,
    input logic rst,
    mm_mac_sequencer_if.slave mac
);
    logic [2*DATA_W-1:0] prod;
    assign prod = mac.mac_a * mac.mac_b;
    // Narrow ACC_W wraps modulo 2^ACC_W by truncation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mac.mac_acc <= '0;
        else if (mac.mac_en) mac.mac_acc <= (mac.mac_clr ? '0 : mac.mac_acc) + ACC_W'(prod);
    end
endmodule

// File: rtl/mm_mac_sequencer.sv
// mm_mac_sequencer: drives one shared MAC through the 27 products of a 3x3 matrix multiply.
module mm_mac_sequencer
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int ACC_W = MM_ACC_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic [MM_N*MM_N*DATA_W-1:0] a_flat,
    input  logic [MM_N*MM_N*DATA_W-1:0] b_flat,
    output logic [MM_N*MM_N*ACC_W-1:0] c_flat,
    output logic busy,
    output logic done,
    mm_mac_sequencer_if.master mac
);
    state_t state, state_d;
    logic [1:0] i, j, k, cap_i, cap_j;
    logic [MM_N*MM_N*DATA_W-1:0] a_q, b_q;
    logic pend, last;

    assign last = i == 2'd2 && j == 2'd2 && k == 2'd2;
    assign busy = state != IDLE;

    always_comb begin
        state_d = IDLE;
        mac.mac_en = 1'b0;
        mac.mac_clr = 1'b0;
        mac.mac_a = '0;
        mac.mac_b = '0;
        state_d = state == IDLE ? (start ? ISSUE : IDLE)
                : abort ? IDLE
                : state == ISSUE ? (last ? DRAIN : ISSUE) : IDLE;
        if (state == ISSUE) begin
            mac.mac_en = 1'b1;
            mac.mac_clr = k == 2'd0;
            mac.mac_a = a_q[idx(int'(i), int'(k))*DATA_W +: DATA_W];
            mac.mac_b = b_q[idx(int'(k), int'(j))*DATA_W +: DATA_W];
        end
    end

    // The sum for (cap_i,cap_j) is visible on mac_acc one cycle after its k==2 issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {i, j, k, cap_i, cap_j} <= '0;
            a_q <= '0;
            b_q <= '0;
            c_flat <= '0;
            pend <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_d;
            done <= state == DRAIN && !abort;
            pend <= mac.mac_en && k == 2'd2 && !abort;
            if (pend) c_flat[idx(int'(cap_i), int'(cap_j))*ACC_W +: ACC_W] <= mac.mac_acc;
            if (state == IDLE && start) begin
                a_q <= a_flat;
                b_q <= b_flat;
                {i, j, k} <= '0;
            end else if (mac.mac_en) begin
                k <= k == 2'd2 ? 2'd0 : k + 2'd1;
                if (k == 2'd2) begin
                    cap_i <= i;
                    cap_j <= j;
                    j <= j == 2'd2 ? 2'd0 : j + 2'd1;
                    if (j == 2'd2) i <= i == 2'd2 ? 2'd0 : i + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mm_mac_sequencer.sv
// tb_mm_mac_sequencer: sequencer+MAC pairs at ACC_W=18 and 16 checked against a cycle-level
// model of the product schedule, plus literal expectations for directed scenarios.
module tb_mm_mac_sequencer;
    import mm_pkg::*;
    localparam int DW = 8;
    localparam int AW = 18;
    localparam int AW16 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [9*DW-1:0] a_flat = '0;
    logic [9*DW-1:0] b_flat = '0;
    logic [9*AW-1:0] c_flat;
    logic [9*AW16-1:0] c16;
    logic busy, done, busy16, done16;

    mm_mac_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) mac_if ();
    mm_mac_sequencer_if #(.DATA_W(DW), .ACC_W(AW16)) mac16_if ();

    mm_mac_sequencer #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a_flat(a_flat), .b_flat(b_flat),
        .c_flat(c_flat), .busy(busy), .done(done), .mac(mac_if));
    mm_mac_unit #(.DATA_W(DW), .ACC_W(AW)) mac_u (.clk(clk), .rst(rst), .mac(mac_if));
    mm_mac_sequencer #(.DATA_W(DW), .ACC_W(AW16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a_flat(a_flat), .b_flat(b_flat),
        .c_flat(c16), .busy(busy16), .done(done16), .mac(mac16_if));
    mm_mac_unit #(.DATA_W(DW), .ACC_W(AW16)) mac16_u (.clk(clk), .rst(rst), .mac(mac16_if));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] pk(input int unsigned v[9], input int w);
        logic [255:0] r = '0;
        for (int n = 0; n < 9; n++) r |= (256'(v[n]) & ((256'(1) << w) - 1)) << (n * w);
        return r;
    endfunction

    // Model: an accepted start opens a 28-cycle window; cycle t issues product t-1, and
    // element e = 3i+j is written at the edge closing cycle 3e+4.
    int unsigned ma[9], mb[9], mc[9], mc16[9];
    bit m_active, m_done;
    int m_t;

    function automatic longint unsigned dot(input int e);
        longint unsigned s = 0;
        for (int q = 0; q < 3; q++) s += longint'(ma[3*(e/3)+q]) * longint'(mb[3*q+e%3]);
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int e;
        if (rst) begin
            m_active = 0;
            m_done = 0;
            m_t = 0;
            for (int n = 0; n < 9; n++) begin
                ma[n] = 0; mb[n] = 0; mc[n] = 0; mc16[n] = 0;
            end
        end else begin
            m_done = m_active && m_t == 28 && !abort;
            if (!m_active) begin
                if (start) begin
                    for (int n = 0; n < 9; n++) begin
                        ma[n] = int'(a_flat[n*DW +: DW]);
                        mb[n] = int'(b_flat[n*DW +: DW]);
                    end
                    m_active = 1;
                    m_t = 1;
                end
            end else begin
                if (m_t >= 4 && (m_t - 4) % 3 == 0) begin
                    e = (m_t - 4) / 3;
                    mc[e] = int'(dot(e) % (64'd1 << AW));
                    mc16[e] = int'(dot(e) % (64'd1 << AW16));
                end
                if (abort || m_t == 28) m_active = 0;
                else m_t++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit en;
        int n;
        if (!rst) begin
            en = m_active && m_t <= 27;
            n = m_t - 1;
            check("busy", 256'(busy), 256'(m_active));
            check("done", 256'(done), 256'(m_done));
            check("mac_en", 256'(mac_if.mac_en), 256'(en));
            check("mac_clr", 256'(mac_if.mac_clr), 256'(en && n % 3 == 0));
            check("mac_a", 256'(mac_if.mac_a), en ? 256'(ma[3*(n/9)+n%3]) : 256'(0));
            check("mac_b", 256'(mac_if.mac_b), en ? 256'(mb[3*(n%3)+(n/3)%3]) : 256'(0));
            check("c_flat", 256'(c_flat), pk(mc, AW));
            check("c16", 256'(c16), pk(mc16, AW16));
            check("done16", 256'(done16), 256'(m_done));
            check("busy16", 256'(busy16), 256'(m_active));
        end
    end

    int en_cnt;
    logic [63:0] clr_m, done_m, busy_m;

    // Cycle c is observed at the c-th falling edge; inputs set there are sampled at edge c.
    task automatic run(input int n, input logic [63:0] st, input logic [63:0] ab, input bit zero1);
        en_cnt = 0;
        clr_m = '0;
        done_m = '0;
        busy_m = '0;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c > 0) begin
                en_cnt += int'(mac_if.mac_en);
                clr_m[c] = mac_if.mac_clr;
                done_m[c] = done;
                busy_m[c] = busy;
            end
            start = st[c];
            abort = ab[c];
            if (zero1 && c == 1) begin
                a_flat = '0;
                b_flat = '0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic rand_ab();
        for (int n = 0; n < 9; n++) begin
            a_flat[n*DW +: DW] = DW'($urandom_range(0, 255));
            b_flat[n*DW +: DW] = DW'($urandom_range(0, 255));
        end
    endtask

    int unsigned ident[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int unsigned seq[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int unsigned bv[9];

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_c", 256'(c_flat), 256'(0));
        check("rst_busy_done", 256'({busy, done}), 256'(0));
        check("rst_mac", 256'({mac_if.mac_en, mac_if.mac_clr, mac_if.mac_a, mac_if.mac_b}), 256'(0));

        a_flat = pk(ident, DW)[9*DW-1:0];
        b_flat = pk(seq, DW)[9*DW-1:0];
        run(32, 64'h1, 64'h0, 1'b0);
        check("t1_en_cnt", 256'(en_cnt), 256'(27));
        check("t1_clr_cycles", 256'(clr_m), 256'(64'h2492492));
        check("t1_done_cycle", 256'(done_m), 256'(64'h2000_0000));
        check("t1_busy_cycles", 256'(busy_m), 256'(64'h1FFF_FFFE));
        check("t1_c", 256'(c_flat), pk('{1, 2, 3, 4, 5, 6, 7, 8, 9}, AW));

        a_flat = '1;
        b_flat = '1;
        run(32, 64'h1, 64'h0, 1'b0);
        check("t2_c18", 256'(c_flat), pk('{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075}, AW));
        check("t2_c16", 256'(c16), pk('{64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003}, AW16));

        a_flat = pk(ident, DW)[9*DW-1:0];
        b_flat = pk(seq, DW)[9*DW-1:0];
        run(35, 64'h1, 64'h400, 1'b0);
        check("t3_no_done", 256'(done_m), 256'(0));
        check("t3_busy_cycles", 256'(busy_m), 256'(64'h7FE));
        check("t3_en_cnt", 256'(en_cnt), 256'(10));
        check("t3_c18", 256'(c_flat), pk('{1, 2, 3, 195075, 195075, 195075, 195075, 195075, 195075}, AW));
        check("t3_c16", 256'(c16), pk('{1, 2, 3, 64003, 64003, 64003, 64003, 64003, 64003}, AW16));
        rand_ab();
        run(32, 64'h1, 64'h0, 1'b0);
        check("t3_restart_done", 256'(done_m), 256'(64'h2000_0000));

        rand_ab();
        run(32, 64'h0010_0021, 64'h0, 1'b0);
        check("t4_one_done", 256'(done_m), 256'(64'h2000_0000));

        rand_ab();
        run(62, 64'h3FFF_FFFF, 64'h0, 1'b0);
        check("t5_two_dones", 256'(done_m), 256'(64'h0400_0000_2000_0000));
        check("t5_en_cnt", 256'(en_cnt), 256'(54));

        rand_ab();
        run(14, 64'h1, 64'h0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_c", 256'(c_flat), 256'(0));
        check("t6_rst_busy_done", 256'({busy, done, busy16, done16}), 256'(0));
        check("t6_rst_mac", 256'({mac_if.mac_en, mac_if.mac_clr, mac_if.mac_a, mac_if.mac_b}), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(20, 64'h0, 64'h0, 1'b0);
        check("t6_no_done", 256'(done_m), 256'(0));
        a_flat = pk(ident, DW)[9*DW-1:0];
        for (int n = 0; n < 9; n++) bv[n] = $urandom_range(0, 255);
        b_flat = pk(bv, DW)[9*DW-1:0];
        run(32, 64'h1, 64'h0, 1'b0);
        check("t6_c_eq_b", 256'(c_flat), pk(bv, AW));

        a_flat = pk(ident, DW)[9*DW-1:0];
        b_flat = pk(seq, DW)[9*DW-1:0];
        run(32, 64'h1, 64'h0, 1'b1);
        check("t7_latched", 256'(c_flat), pk('{1, 2, 3, 4, 5, 6, 7, 8, 9}, AW));

        repeat (10) begin
            rand_ab();
            run(40, 64'h1 | ({32'h0, $urandom} & 64'hF0F0_0F00),
                $urandom_range(0, 1) == 1 ? 64'h1 << $urandom_range(1, 28) : 64'h0, 1'b0);
        end
        run(35, 64'h0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
